// File: rtl/uart_rx_if.sv
// Serial-side bundle for the UART receiver: line and tick in, byte, status and strobe out.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, frame_err, busy
  );

  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1-style UART receiver: synchronises rx, deserialises LSB first,
// and reports each frame with a one-cycle done strobe and a framing-error flag.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic     sys_clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic            rxMeta_q, rxSync_q;
  logic            rxS;
  state_t          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= bus.rx;
      rxSync_q <= rxMeta_q;
    end
  end

  assign rxS = rxSync_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      // The falling edge is taken immediately; a tick on this cycle is ignored.
      IDLE: begin
        if (!rxS) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == 5'd7) begin
            if (!rxS) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            b_d = {rxS, b_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rxS;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.frame_err    = ferr_q;
  assign bus.rx_done_tick = done_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the 16x-oversampled serial path. It consumes the single-cycle `sample_tick` strobe produced by the baud-rate generator and deserialises an asynchronous 8N1 frame (LSB first) from the `rx` pin. It presents the received byte with a one-cycle done strobe and a framing-error flag. It sits between the pad and the RX FIFO / host interface.

## Interface
Parameters:
- `DBIT`, default 8: number of data bits per frame (5..8).
- `SB_TICK`, default 16: sample ticks spent in the stop phase (16, 24 or 32 for 1, 1.5 or 2 stop bits).

Ports (reset `rst` is asynchronous and active-high; the clock is `sys_clk`):
- `sys_clk`, input, 1: system clock (50 MHz nominal).
- `rst`, input, 1: asynchronous, active-high reset.
- `rx`, input, 1: serial line, asynchronous to `sys_clk`, idle high.
- `s_tick`, input, 1: 16x oversample strobe, one `sys_clk` cycle wide, from the baud generator.
- `dout`, output, DBIT: last received data byte.
- `rx_done_tick`, output, 1: one-cycle pulse when `dout` and `frame_err` update.
- `frame_err`, output, 1: stop bit sampled low on the last frame.
- `busy`, output, 1: FSM not in IDLE.

## Operation
- **Synchroniser**
  - `rx` passes through a 2-flop synchroniser; the output is `rx_s`.
  - Both flops reset to 1.
  - The FSM uses only `rx_s`.
- **Registers**
  - `state`: IDLE, START, DATA or STOP.
  - `s`: 5-bit tick counter.
  - `n`: `$clog2(DBIT)`-bit bit counter, minimum 1 bit.
  - `b`: DBIT-bit shift register.
- **Tick qualification:** the `s`, `n` and `b` counters and state changes (other than IDLE→START) advance only on cycles where `s_tick`=1.
- **IDLE**
  - When `rx_s`=0, go to START with `s`=0.
  - This transition does not wait for `s_tick`.
- **START**
  - On a tick with `s`==7, i.e. mid start bit:
    - if `rx_s`=0, go to DATA with `s`=0 and `n`=0;
    - if `rx_s`=1, this is a false start; go to IDLE with no output change.
  - On any other tick, `s`++.
- **DATA**
  - On a tick with `s`==15: set `s`=0 and `b` = {`rx_s`, `b`[DBIT-1:1]} (LSB first).
  - Then, if `n`==DBIT-1, go to STOP; otherwise `n`++.
  - On any other tick, `s`++.
- **STOP**
  - On a tick with `s`==SB_TICK-1, go to IDLE and, on the same edge:
    - `dout`<=`b`;
    - `frame_err`<=~`rx_s`;
    - `rx_done_tick`<=1.
  - On any other tick, `s`++.
  - STOP ends at mid stop bit, so the next start edge can be detected immediately (back-to-back frames).
- **Outputs**
  - `dout` and `frame_err` hold their values until the next frame completes.
  - A frame with a framing error still updates `dout`.
  - `busy` = (`state`≠IDLE), registered-state derived and glitch-free.
- **Reset**
  - Reset values: `state`=IDLE, `s`=0, `n`=0, `b`=0, `dout`=0, `rx_done_tick`=0, `frame_err`=0, `busy`=0, synchroniser=1.
  - A reset mid-frame aborts the frame with no done pulse.
  - After release, a line held low is treated as a new start edge.
- **Simultaneous events:** `s_tick` on the same cycle as the IDLE→START transition is not counted; counting starts on the next tick.

## Timing
- `rx` to `rx_s` latency: 2 `sys_clk` cycles.
- Start detection: START is entered 1 cycle after `rx_s` falls.
- Sampling points, counted from the start-edge detection:
  - start-bit check: 8th tick;
  - data bit k: tick 8+16·(k+1);
  - end of stop phase: tick 8+16·DBIT+SB_TICK.
- `rx_done_tick` is high for exactly one `sys_clk` cycle, immediately after the edge that samples the final stop tick.
- The `dout`/`frame_err` update is visible in the same cycle as `rx_done_tick`.
- Tolerance: ±(7/16) bit of accumulated drift at the last sample point.
- At 50 MHz / 19200 baud the tick period is 163 cycles, so one frame is about 26 000 cycles.

## Test plan
- **Nominal frame:** send 0xA5 at 19200 baud (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with the real baud generator → exactly one `rx_done_tick`, `dout`=0xA5, `frame_err`=0, and `busy` low after done.
- **Start glitch:** drive `rx` low for 4 ticks, then high → return to IDLE after the mid-start check, no `rx_done_tick`, `dout` unchanged.
- **Framing error:** send 0x3C with stop bit 0 → `rx_done_tick`=1, `dout`=0x3C, `frame_err`=1. A following good frame 0x01 clears `frame_err`=0.
- **Back-to-back frames:** 0x00 then 0xFF with no idle gap (next start bit right after the stop bit) → two done pulses, `dout`=0x00 then 0xFF, both `frame_err`=0.
- **Reset mid-frame:** assert `rst` during data bit 3 → all outputs 0 asynchronously and `busy`=0. After release, send frame 0x5A → `dout`=0x5A.
- **Baud skew:** transmitter at ±3 % of 19200 sending 0x96 → `dout`=0x96, `frame_err`=0.
